avl_mm_ram_agent: RTL and testbench
===================================

Name: avl_mm_ram_agent

Overview:
- Avalon-MM agent that sits directly downstream of a host on the avl_mm_mini_if agent modport.
- Consumes read and write commands and backs them with an internal word-addressed RAM of 2**ADDR_WIDTH words.
- Inserts programmable wait states, returns pipelined read data with a fixed latency, and throttles outstanding reads.
- Used as the target stage for host-side driver and monitor tests.

Parameters:
- DATA_WIDTH, 32, width of readdata and writedata; must match the interface.
- ADDR_WIDTH, 8, word address width; RAM depth is 2**ADDR_WIDTH.
- WAIT_STATES, 0, number of cycles waitrequest stays high before each command is accepted; range 0..15.
- READ_LATENCY, 2, cycles from the read-accept edge to readdatavalid; range 1..8.
- MAX_PENDING, 4, maximum number of accepted reads not yet returned; range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- avl  interface  -  avl_mm_mini_if.agnt modport (read, write, address, writedata in; waitrequest, readdata, readdatavalid out).
- protocol_err  output  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset values:
  - waitrequest=1; readdatavalid=0; readdata=0; protocol_err=0.
  - Wait-state counter and outstanding counter are 0; read pipeline is empty.
  - RAM contents are not reset.
- Async assert and async clear of all state. On the first edge after reset deasserts, waitrequest follows its normal rule.
- waitrequest is driven from registered state only: waitrequest = (ws_cnt < WAIT_STATES) || (outstanding == MAX_PENDING).
- ws_cnt:
  - Increments each cycle (read|write) is high and waitrequest is high.
  - Clears to 0 on accept; stays 0 while idle.
  - With WAIT_STATES=0, a command is accepted in its first cycle unless reads are throttled.
- Accept condition: (read|write) && !waitrequest. The host holds address and writedata stable until accept.
- Write: on the accept edge, RAM[address] <= writedata. No response is generated.
- Read accept:
  - RAM[address] is sampled on the accept edge.
  - The data travels a READ_LATENCY-deep valid/data delay line.
  - readdatavalid is high for exactly one cycle, READ_LATENCY cycles after the accept edge.
- readdata holds its last returned value while readdatavalid=0.
- Back-to-back reads are accepted every cycle (when WAIT_STATES=0). Responses return in order, one per cycle.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. A read accepted in the same cycle as the write is impossible because only one command is accepted per cycle.
- outstanding counter:
  - +1 on read accept, -1 on readdatavalid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_PENDING and never underflows.
- When outstanding == MAX_PENDING, waitrequest is high; writes are also stalled.
- read and write both high: write wins, the read is ignored, and protocol_err sets (with the feature enabled).
- Address wrap: address is ADDR_WIDTH wide, so no out-of-range case exists.
- Reset mid-operation: in-flight reads are discarded with no readdatavalid after reset, and counters clear. RAM keeps completed writes.

Optional Feature:
- Macro: AVL_MM_RAM_AGENT_CHECK_EN.
- Enabled, protocol_err sets sticky (cleared only by reset) on any of:
  - read && write in the same cycle;
  - address or writedata changing while a command is held under waitrequest;
  - read or write dropping before accept.
- Enabled, matching SVA immediate assertions also fire in simulation.
- Disabled: protocol_err is tied 0 and no checking logic is present.

Decomposition:
- Package avl_mm_ram_agent_pkg holds:
  - the rd_stage_t struct {logic vld; logic [DATA_WIDTH-1:0] data} parameterised via a typedef in the module;
  - localparam widths for the ws_cnt and outstanding counters (4 bits each);
  - parameter-range check functions.
- One sub-module, avl_mm_rd_pipe: the READ_LATENCY-deep valid/data delay line with async reset.

Test Plan:
- Reset held 3 cycles with read=1 -> waitrequest=1, readdatavalid=0, readdata=0 throughout; no accept.
- WAIT_STATES=0, READ_LATENCY=2: write 0xDEADBEEF to addr 0x10, then read 0x10 next cycle -> readdatavalid one cycle, 2 cycles after the read accept, readdata=0xDEADBEEF.
- WAIT_STATES=3: single write held -> waitrequest high 3 cycles, accepted on the 4th; RAM updated once only.
- MAX_PENDING=4, READ_LATENCY=8: 6 back-to-back reads to 0..5 -> first 4 accepted consecutively, waitrequest high until the first return; all 6 responses in order with matching data.
- Sustained reads with MAX_PENDING=2, READ_LATENCY=1: accept and return in the same cycle -> outstanding stays at 1, no stall, one response per cycle.
- CHECK_EN: read=write=1 at addr 0x20 -> write performed, no readdatavalid, protocol_err=1 and it stays 1 until reset.

Source files
------------

// File: rtl/avl_mm_ram_agent_pkg.sv
// Shared counter widths and parameter-range checks for the Avalon-MM RAM agent.
package avl_mm_ram_agent_pkg;

    localparam int WS_CNT_W  = 4;
    localparam int OUT_CNT_W = 4;

    function automatic bit wait_states_ok(input int ws);
        return (ws >= 0) && (ws <= 15);
    endfunction

    function automatic bit read_latency_ok(input int rl);
        return (rl >= 1) && (rl <= 8);
    endfunction

    function automatic bit max_pending_ok(input int mp);
        return (mp >= 1) && (mp <= 15);
    endfunction

endpackage

// File: rtl/avl_mm_mini_if.sv
// Minimal Avalon-MM bus: host drives commands, agent answers with waitrequest and read data.
interface avl_mm_mini_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport host (
        output read, write, address, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport agnt (
        input  read, write, address, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avl_mm_rd_pipe.sv
// Fixed-latency valid/data delay line for read responses; each stage only loads data
// when its source is valid, so the last stage holds the previous response.
module avl_mm_rd_pipe
    import avl_mm_ram_agent_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] data;
    } rd_stage_t;

    rd_stage_t stage_q [READ_LATENCY];
    rd_stage_t src     [READ_LATENCY];

    always_comb begin
        src[0] = '{vld: in_vld, data: in_data};
        for (int i = 1; i < READ_LATENCY; i++) begin
            src[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i].vld <= src[i].vld;
                if (src[i].vld) begin
                    stage_q[i].data <= src[i].data;
                end
            end
        end
    end

    assign out_vld  = stage_q[READ_LATENCY-1].vld;
    assign out_data = stage_q[READ_LATENCY-1].data;

endmodule

// File: rtl/avl_mm_ram_agent.sv
// Avalon-MM RAM agent: wait-state insertion, fixed-latency pipelined reads, read throttling.
// Optional protocol checker and sticky protocol_err enabled by AVL_MM_RAM_AGENT_CHECK_EN.
module avl_mm_ram_agent
    import avl_mm_ram_agent_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int WAIT_STATES  = 0,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        reset,
    avl_mm_mini_if.agnt avl,
    output logic        protocol_err
);

    localparam logic [OUT_CNT_W-1:0] PEND_LIM = OUT_CNT_W'(MAX_PENDING);

    if (!(wait_states_ok(WAIT_STATES) && read_latency_ok(READ_LATENCY)
          && max_pending_ok(MAX_PENDING))) begin : g_bad_cfg
        $error("avl_mm_ram_agent: parameter outside supported range");
    end

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [OUT_CNT_W-1:0]  pend_q;
    logic                  waitreq;
    logic                  ws_wait;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    // Command inputs never feed waitrequest; only counters and reset do.
    assign waitreq = reset || ws_wait || (pend_q == PEND_LIM);
    assign wr_acc  = avl.write && !waitreq;
    assign rd_acc  = avl.read && !avl.write && !waitreq;

    if (WAIT_STATES == 0) begin : g_no_ws
        assign ws_wait = 1'b0;
    end else begin : g_ws
        localparam logic [WS_CNT_W-1:0] WS_LIM = WS_CNT_W'(WAIT_STATES);
        logic [WS_CNT_W-1:0] ws_cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ws_cnt_q <= '0;
            end else if (!(avl.read || avl.write) || !waitreq) begin
                ws_cnt_q <= '0;
            end else if (ws_cnt_q != WS_LIM) begin
                ws_cnt_q <= ws_cnt_q + 1'b1;
            end
        end

        assign ws_wait = ws_cnt_q < WS_LIM;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[avl.address] <= avl.writedata;
        end
    end

    avl_mm_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (rd_acc),
        .in_data  (mem[avl.address]),
        .out_vld  (rvalid),
        .out_data (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else if (rd_acc && !rvalid) begin
            pend_q <= pend_q + 1'b1;
        end else if (!rd_acc && rvalid) begin
            pend_q <= pend_q - 1'b1;
        end
    end

    assign avl.waitrequest   = waitreq;
    assign avl.readdatavalid = rvalid;
    assign avl.readdata      = rdata;

`ifdef AVL_MM_RAM_AGENT_CHECK_EN
    logic                  rd_held_q;
    logic                  wr_held_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  viol_rw;
    logic                  viol_hold;
    logic                  viol_drop;

    always_comb begin
        viol_rw   = avl.read && avl.write;
        viol_hold = (rd_held_q || wr_held_q) && (avl.read || avl.write)
                    && ((avl.address != addr_q) || (wr_held_q && (avl.writedata != wdata_q)));
        viol_drop = (rd_held_q && !avl.read) || (wr_held_q && !avl.write);
        if (!reset) begin
            a_no_rw:   assert (!viol_rw)   else $warning("avl agent: read and write both high");
            a_stable:  assert (!viol_hold) else $warning("avl agent: command changed under waitrequest");
            a_no_drop: assert (!viol_drop) else $warning("avl agent: command dropped before accept");
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_held_q <= 1'b0;
            wr_held_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_held_q <= avl.read && waitreq;
            wr_held_q <= avl.write && waitreq;
            addr_q    <= avl.address;
            wdata_q   <= avl.writedata;
            if (viol_rw || viol_hold || viol_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_avl_mm_ram_agent.sv
// Directed bench for avl_mm_ram_agent: four instances cover latency, wait-state,
// throttling and sustained-read configurations.
module tb_avl_mm_ram_agent;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

`ifdef AVL_MM_RAM_AGENT_CHECK_EN
    localparam logic [31:0] EXP_PERR = 32'd1;
`else
    localparam logic [31:0] EXP_PERR = 32'd0;
`endif

    avl_mm_mini_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ia ();
    avl_mm_mini_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ib ();
    avl_mm_mini_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ic ();
    avl_mm_mini_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) id ();
    logic perr_a, perr_b, perr_c, perr_d;

    avl_mm_ram_agent #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0), .READ_LATENCY(2), .MAX_PENDING(4))
        u_dut_a (.clk(clk), .reset(reset), .avl(ia), .protocol_err(perr_a));
    avl_mm_ram_agent #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(3), .READ_LATENCY(2), .MAX_PENDING(4))
        u_dut_b (.clk(clk), .reset(reset), .avl(ib), .protocol_err(perr_b));
    avl_mm_ram_agent #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0), .READ_LATENCY(8), .MAX_PENDING(4))
        u_dut_c (.clk(clk), .reset(reset), .avl(ic), .protocol_err(perr_c));
    avl_mm_ram_agent #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0), .READ_LATENCY(1), .MAX_PENDING(2))
        u_dut_d (.clk(clk), .reset(reset), .avl(id), .protocol_err(perr_d));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic exp_v;
        logic acc;
        logic any_rdv;
        int   rd_idx;
        int   resp_idx;

        reset = 1'b1;
        ia.read = 1'b1; ia.write = 1'b0; ia.address = '0; ia.writedata = '0;
        ib.read = 1'b0; ib.write = 1'b0; ib.address = '0; ib.writedata = '0;
        ic.read = 1'b0; ic.write = 1'b0; ic.address = '0; ic.writedata = '0;
        id.read = 1'b0; id.write = 1'b0; id.address = '0; id.writedata = '0;

        // reset held with read asserted
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("rst_wreq",  32'(ia.waitrequest), 32'd1);
            chk("rst_rdv",   32'(ia.readdatavalid), 32'd0);
            chk("rst_rdata", ia.readdata, 32'd0);
        end
        chk("rst_perr", 32'(perr_a), 32'd0);
        reset   = 1'b0;
        ia.read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("post_rst_rdv", 32'(ia.readdatavalid), 32'd0);
        end
        chk("idle_wreq_ws0", 32'(ia.waitrequest), 32'd0);

        // write then read-after-write, latency 2
        ia.write = 1'b1; ia.address = 8'h10; ia.writedata = 32'hDEADBEEF;
        chk("raw_wr_wreq", 32'(ia.waitrequest), 32'd0);
        tick;
        ia.write = 1'b0; ia.read = 1'b1;
        chk("raw_rd_wreq", 32'(ia.waitrequest), 32'd0);
        tick;
        ia.read = 1'b0;
        chk("raw_rdv_early", 32'(ia.readdatavalid), 32'd0);
        tick;
        chk("raw_rdv", 32'(ia.readdatavalid), 32'd1);
        chk("raw_rdata", ia.readdata, 32'hDEADBEEF);
        tick;
        chk("raw_rdv_once", 32'(ia.readdatavalid), 32'd0);
        chk("raw_rdata_hold", ia.readdata, 32'hDEADBEEF);

        // back-to-back reads
        for (int i = 0; i < 4; i++) begin
            ia.write = 1'b1; ia.address = 8'(8'h40 + i); ia.writedata = 32'(32'hA500_0000 + i);
            chk("b2b_wr_wreq", 32'(ia.waitrequest), 32'd0);
            tick;
        end
        ia.write = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                ia.read = 1'b1; ia.address = 8'(8'h40 + c);
                chk("b2b_rd_wreq", 32'(ia.waitrequest), 32'd0);
            end else begin
                ia.read = 1'b0;
            end
            tick;
            exp_v = (c >= 1) && (c <= 4);
            chk($sformatf("b2b_rdv_c%0d", c), 32'(ia.readdatavalid), 32'(exp_v));
            if (exp_v) chk($sformatf("b2b_rdata_c%0d", c), ia.readdata, 32'(32'hA500_0000 + c - 1));
        end

        // read and write together: write wins
        ia.read = 1'b1; ia.write = 1'b1; ia.address = 8'h20; ia.writedata = 32'h12345678;
        tick;
        ia.read = 1'b0; ia.write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("rw_no_rdv", 32'(ia.readdatavalid), 32'd0);
            chk("rw_perr", 32'(perr_a), EXP_PERR);
        end
        ia.read = 1'b1;
        tick;
        ia.read = 1'b0;
        tick;
        chk("rw_rd_rdv", 32'(ia.readdatavalid), 32'd1);
        chk("rw_rd_rdata", ia.readdata, 32'h12345678);

        // three wait states
        ib.write = 1'b1; ib.address = 8'h05; ib.writedata = 32'hCAFE0005;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ws_wr_wreq_hi%0d", k), 32'(ib.waitrequest), 32'd1);
            tick;
        end
        chk("ws_wr_wreq_lo", 32'(ib.waitrequest), 32'd0);
        tick;
        ib.write = 1'b0;
        chk("ws_after_acc_wreq", 32'(ib.waitrequest), 32'd1);
        ib.read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("ws_rd_wreq_hi", 32'(ib.waitrequest), 32'd1);
            tick;
        end
        chk("ws_rd_wreq_lo", 32'(ib.waitrequest), 32'd0);
        tick;
        ib.read = 1'b0;
        chk("ws_rdv_early", 32'(ib.readdatavalid), 32'd0);
        tick;
        chk("ws_rdv", 32'(ib.readdatavalid), 32'd1);
        chk("ws_rdata", ib.readdata, 32'hCAFE0005);

        // throttling: MAX_PENDING=4, latency 8
        for (int i = 0; i < 6; i++) begin
            ic.write = 1'b1; ic.address = 8'(i); ic.writedata = 32'(32'hC0DE_0000 + i);
            chk("thr_wr_wreq", 32'(ic.waitrequest), 32'd0);
            tick;
        end
        ic.write = 1'b0;
        rd_idx   = 0;
        resp_idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_idx < 6) begin
                ic.read = 1'b1; ic.address = 8'(rd_idx);
            end else begin
                ic.read = 1'b0;
            end
            if (c <= 10) chk($sformatf("thr_wreq_c%0d", c), 32'(ic.waitrequest), 32'((c >= 4) && (c <= 8)));
            acc = ic.read && !ic.waitrequest;
            tick;
            if (acc) rd_idx++;
            exp_v = (c == 7) || (c == 8) || (c == 9) || (c == 10) || (c == 16) || (c == 17);
            chk($sformatf("thr_rdv_c%0d", c), 32'(ic.readdatavalid), 32'(exp_v));
            if (exp_v) begin
                chk($sformatf("thr_rdata_c%0d", c), ic.readdata, 32'(32'hC0DE_0000 + resp_idx));
                resp_idx++;
            end
        end
        ic.read = 1'b0;
        chk("thr_all_acc", 32'(rd_idx), 32'd6);

        // sustained reads: latency 1, MAX_PENDING=2
        for (int i = 0; i < 8; i++) begin
            id.write = 1'b1; id.address = 8'(8'h80 + i); id.writedata = 32'(32'hD000_0000 + i);
            tick;
        end
        id.write = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                id.read = 1'b1; id.address = 8'(8'h80 + c);
                chk($sformatf("sus_wreq_c%0d", c), 32'(id.waitrequest), 32'd0);
            end else begin
                id.read = 1'b0;
            end
            tick;
            exp_v = (c <= 7);
            chk($sformatf("sus_rdv_c%0d", c), 32'(id.readdatavalid), 32'(exp_v));
            if (exp_v) chk($sformatf("sus_rdata_c%0d", c), id.readdata, 32'(32'hD000_0000 + c));
        end

        chk("perr_sticky", 32'(perr_a), EXP_PERR);
        chk("perr_b_clean", 32'(perr_b), 32'd0);
        chk("perr_c_clean", 32'(perr_c), 32'd0);
        chk("perr_d_clean", 32'(perr_d), 32'd0);

        // reset with a read in flight
        ic.read = 1'b1; ic.address = 8'h02;
        chk("midrst_wreq_pre", 32'(ic.waitrequest), 32'd0);
        tick;
        ic.read = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("midrst_rdv", 32'(ic.readdatavalid), 32'd0);
        chk("midrst_wreq", 32'(ic.waitrequest), 32'd1);
        chk("midrst_perr_clr", 32'(perr_a), 32'd0);
        tick;
        reset   = 1'b0;
        any_rdv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (ic.readdatavalid) any_rdv = 1'b1;
        end
        chk("midrst_no_rdv", 32'(any_rdv), 32'd0);
        ic.read = 1'b1; ic.address = 8'h02;
        tick;
        ic.read = 1'b0;
        for (int k = 0; k < 6; k++) tick;
        chk("midrst_rdv_early", 32'(ic.readdatavalid), 32'd0);
        tick;
        chk("midrst_ram_rdv", 32'(ic.readdatavalid), 32'd1);
        chk("midrst_ram_rdata", ic.readdata, 32'hC0DE0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
